// File: rtl/regfile_pkg.sv
// Shared sizing constants and address type for the register file.
package regfile_pkg;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_reset_register32.sv
// One storage register with write enable and asynchronous active-high clear.
module register32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_reset.sv
// 32-entry register file: two combinational read ports, one clocked write port,
// async clear, optional write-to-read bypass. Register 0 always reads zero.
module regfile_reset
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_WIDTH,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] WriteData,
  input  addr_t            ReadRegister1,
  input  addr_t            ReadRegister2,
  input  addr_t            WriteRegister,
  input  logic             RegWrite
);

  logic [REG_COUNT-1:0] wr_sel;
  logic [WIDTH-1:0]     regs [REG_COUNT];
  logic                 hit1;
  logic                 hit2;

  // One-hot write decode; address 0 never selects anything.
  always_comb begin
    wr_sel = '0;
    if (RegWrite && (WriteRegister != ZERO_REG)) begin
      wr_sel[WriteRegister] = 1'b1;
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < REG_COUNT; g++) begin : g_reg
    register32 #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk(Clk),
      .rst(Reset),
      .en (wr_sel[g]),
      .d  (WriteData),
      .q  (regs[g])
    );
  end

  // Forward the in-flight write to a reader of the same address when enabled.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (BYPASS && RegWrite && !Reset && (WriteRegister != ZERO_REG)) begin
      hit1 = (ReadRegister1 == WriteRegister);
      hit2 = (ReadRegister2 == WriteRegister);
    end
  end

  always_comb begin
    ReadData1 = hit1 ? WriteData : regs[ReadRegister1];
    ReadData2 = hit2 ? WriteData : regs[ReadRegister2];
  end

endmodule

// File: tb/tb_regfile_reset.sv
// Scoreboard bench for regfile_reset: one instance without and one with bypass,
// both driven identically and checked against an array model of the register file.
module tb_regfile_reset;

  logic        clk;
  logic        rst;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic        we;
  logic [31:0] rd1_nb;
  logic [31:0] rd2_nb;
  logic [31:0] rd1_bp;
  logic [31:0] rd2_bp;

  regfile_reset #(.WIDTH(32), .BYPASS(1'b0)) dut_nb (
    .Clk(clk), .Reset(rst), .ReadData1(rd1_nb), .ReadData2(rd2_nb),
    .WriteData(wd), .ReadRegister1(ra1), .ReadRegister2(ra2),
    .WriteRegister(wa), .RegWrite(we)
  );

  regfile_reset #(.WIDTH(32), .BYPASS(1'b1)) dut_bp (
    .Clk(clk), .Reset(rst), .ReadData1(rd1_bp), .ReadData2(rd2_bp),
    .WriteData(wd), .ReadRegister1(ra1), .ReadRegister2(ra2),
    .WriteRegister(wa), .RegWrite(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1_nb;
    logic [31:0] e2_nb;
    logic [31:0] e1_bp;
    logic [31:0] e2_bp;
  } exp_t;

  exp_t        sb_q[$];
  event        sample_ev;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mem [32];

  // Reference: a read sees the stored word, or the write data when forwarding applies.
  function automatic logic [31:0] model_read(input logic [4:0] a, input bit bp);
    if (rst) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (bp && we && (a == wa) && (wa != 5'd0)) return wd;
    return mem[a];
  endfunction

  task automatic compare(input string tag, input string port,
                         input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, port, act, exp);
    end
  endtask

  // Monitor: drains the scoreboard whenever the driver flags a sample point.
  always begin
    @(sample_ev);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      compare(e.tag, "nb.rd1", rd1_nb, e.e1_nb);
      compare(e.tag, "nb.rd2", rd2_nb, e.e2_nb);
      compare(e.tag, "bp.rd1", rd1_bp, e.e1_bp);
      compare(e.tag, "bp.rd2", rd2_bp, e.e2_bp);
    end
  end

  task automatic check(input string tag);
    exp_t e;
    #1;
    e.tag   = tag;
    e.e1_nb = model_read(ra1, 1'b0);
    e.e2_nb = model_read(ra2, 1'b0);
    e.e1_bp = model_read(ra1, 1'b1);
    e.e2_bp = model_read(ra2, 1'b1);
    sb_q.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
    we  = w;
    wa  = a;
    wd  = d;
    ra1 = r1;
    ra2 = r2;
  endtask

  // Advance one clock; the model commits the write the DUT should take at the edge.
  task automatic tick();
    @(posedge clk);
    if (we && !rst && (wa != 5'd0)) mem[wa] = wd;
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_model();
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
    check("reset_r0_r5");
    set_in(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    check("reset_r31");

    set_in(1'b1, 5'd5, 32'd99, 5'd5, 5'd5);
    check("reset_write_pending");
    tick();
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("reset_write_dropped");

    set_in(1'b1, 5'd2, 32'd42, 5'd2, 5'd2);
    tick();
    check("basic_write");

    set_in(1'b0, 5'd2, 32'd300, 5'd2, 5'd2);
    tick();
    check("we0_keep");
    set_in(1'b0, 5'd2, 32'd2273, 5'd1, 5'd21);
    tick();
    check("we0_no_spill");

    set_in(1'b1, 5'd2, 32'd2000, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd17, 32'd17000, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 5'd17, 5'd2);
    check("ports_17_2");
    set_in(1'b0, 5'd0, 32'd0, 5'd2, 5'd17);
    check("ports_2_17");

    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 5'(i), 32'(i * 3), 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      check("sweep");
    end

    set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("r0_write_pending");
    tick();
    check("r0_write_dropped");
    for (int i = 0; i < 32; i++) begin
      set_in(1'b0, 5'd0, 32'hFFFF_FFFF, 5'(i), 5'(i));
      check("r0_no_side_effect");
    end

    set_in(1'b1, 5'd7, 32'h1234, 5'd7, 5'd3);
    check("bypass_pre_edge");
    tick();
    check("bypass_post_edge");
    #2;
    rst = 1'b1;
    clear_model();
    set_in(1'b1, 5'd7, 32'h5678, 5'd7, 5'd17);
    check("async_reset_clear");
    tick();
    check("reset_edge_no_write");
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 5'd7, 5'd3);
    check("after_reset");

    for (int n = 0; n < 300; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 3) != 0), a, $urandom(),
             ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)));
      check("random");
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        clear_model();
        check("random_reset");
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
